// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle; performance counter outputs
// are present only when HAZARD_PERF_CNT_EN is defined.
interface hazard_stall_ctrl_if;
    logic [6:0]  id_instr_opcode_ip;
    logic [4:0]  ID_dest_rs1_ip;
    logic [4:0]  ID_dest_rs2_ip;
    logic [4:0]  ID_EX_dest_ip;
    logic        ID_EX_is_load_ip;
    logic        branch_taken_ip;
    logic        mem_busy_ip;
    logic        pc_stall_op;
    logic        if_id_stall_op;
    logic        id_ex_stall_op;
    logic        ex_mem_stall_op;
    logic        id_ex_bubble_op;
    logic        if_id_flush_op;
    logic        stall_timeout_op;
    logic [1:0]  state_op;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] lu_stall_cnt_op;
    logic [31:0] mem_stall_cnt_op;
    logic [31:0] flush_cnt_op;

    modport master (
        output id_instr_opcode_ip, ID_dest_rs1_ip, ID_dest_rs2_ip, ID_EX_dest_ip,
               ID_EX_is_load_ip, branch_taken_ip, mem_busy_ip,
        input  pc_stall_op, if_id_stall_op, id_ex_stall_op, ex_mem_stall_op,
               id_ex_bubble_op, if_id_flush_op, stall_timeout_op, state_op,
               lu_stall_cnt_op, mem_stall_cnt_op, flush_cnt_op
    );
    modport slave (
        input  id_instr_opcode_ip, ID_dest_rs1_ip, ID_dest_rs2_ip, ID_EX_dest_ip,
               ID_EX_is_load_ip, branch_taken_ip, mem_busy_ip,
        output pc_stall_op, if_id_stall_op, id_ex_stall_op, ex_mem_stall_op,
               id_ex_bubble_op, if_id_flush_op, stall_timeout_op, state_op,
               lu_stall_cnt_op, mem_stall_cnt_op, flush_cnt_op
    );
`else
    modport master (
        output id_instr_opcode_ip, ID_dest_rs1_ip, ID_dest_rs2_ip, ID_EX_dest_ip,
               ID_EX_is_load_ip, branch_taken_ip, mem_busy_ip,
        input  pc_stall_op, if_id_stall_op, id_ex_stall_op, ex_mem_stall_op,
               id_ex_bubble_op, if_id_flush_op, stall_timeout_op, state_op
    );
    modport slave (
        input  id_instr_opcode_ip, ID_dest_rs1_ip, ID_dest_rs2_ip, ID_EX_dest_ip,
               ID_EX_is_load_ip, branch_taken_ip, mem_busy_ip,
        output pc_stall_op, if_id_stall_op, id_ex_stall_op, ex_mem_stall_op,
               id_ex_bubble_op, if_id_flush_op, stall_timeout_op, state_op
    );
`endif
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and memory-wait
// stalls with a sticky timeout flag. HAZARD_PERF_CNT_EN adds event counters.
module hazard_stall_ctrl #(
    parameter int unsigned STALL_LIMIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    hazard_stall_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        FLUSH    = 2'd3
    } state_e;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [4:0] LIMIT      = 5'(STALL_LIMIT);

    state_e     state_q, state_d;
    logic       pending_q, pending_d;
    logic [4:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;
    logic       rs1_used, rs2_used, load_use;
    logic       lu_fire, mem_fire, flush_fire;
    logic       pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, bubble, flush;

    always_comb begin
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (hz.id_instr_opcode_ip)
            OPC_BRANCH, OPC_STORE, OPC_OP: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            OPC_LOAD, OPC_OPIMM, OPC_JALR: rs1_used = 1'b1;
            default: ;
        endcase
    end

    assign load_use = hz.ID_EX_is_load_ip && (hz.ID_EX_dest_ip != '0) &&
                      ((rs1_used && (hz.ID_dest_rs1_ip == hz.ID_EX_dest_ip)) ||
                       (rs2_used && (hz.ID_dest_rs2_ip == hz.ID_EX_dest_ip)));

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        bubble       = 1'b0;
        flush        = 1'b0;
        lu_fire      = 1'b0;
        mem_fire     = 1'b0;
        flush_fire   = 1'b0;
        if (reset) begin
            state_d   = RUN;
            pending_d = 1'b0;
        end else if (hz.mem_busy_ip) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_fire     = 1'b1;
            pending_d    = pending_q | hz.branch_taken_ip;
            state_d      = MEM_WAIT;
        end else begin
            pending_d = 1'b0;
            case (state_q)
                // The cycle memory completes is a normal issue cycle, plus any
                // branch that resolved while the pipeline was frozen.
                RUN, MEM_WAIT: begin
                    if (hz.branch_taken_ip || (state_q == MEM_WAIT && pending_q)) begin
                        flush      = 1'b1;
                        bubble     = 1'b1;
                        flush_fire = 1'b1;
                        state_d    = FLUSH;
                    end else if (load_use) begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        bubble      = 1'b1;
                        lu_fire     = 1'b1;
                        state_d     = LU_STALL;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        cnt_d = '0;
        if (state_d == MEM_WAIT) begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 5'd1;
        end
        timeout_d = timeout_q | ((state_d == MEM_WAIT) && (cnt_d >= LIMIT));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            pending_q <= 1'b0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign hz.pc_stall_op      = pc_stall;
    assign hz.if_id_stall_op   = if_id_stall;
    assign hz.id_ex_stall_op   = id_ex_stall;
    assign hz.ex_mem_stall_op  = ex_mem_stall;
    assign hz.id_ex_bubble_op  = bubble;
    assign hz.if_id_flush_op   = flush;
    assign hz.stall_timeout_op = timeout_q;
    assign hz.state_op         = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] lu_cnt_q, mem_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            lu_cnt_q    <= '0;
            mem_cnt_q   <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (lu_fire)    lu_cnt_q    <= lu_cnt_q + 32'd1;
            if (mem_fire)   mem_cnt_q   <= mem_cnt_q + 32'd1;
            if (flush_fire) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign hz.lu_stall_cnt_op  = lu_cnt_q;
    assign hz.mem_stall_cnt_op = mem_cnt_q;
    assign hz.flush_cnt_op     = flush_cnt_q;
`else
    logic unused_fire;
    assign unused_fire = lu_fire ^ mem_fire ^ flush_fire;
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed vector table, timeout
// sequence and randomized run against a cycle-level behavioural model.
module tb_hazard_stall_ctrl;
    localparam logic [6:0] BRANCH = 7'b1100011, STORE = 7'b0100011, OPR = 7'b0110011;
    localparam logic [6:0] LOAD = 7'b0000011, OPIMM = 7'b0010011, JALR = 7'b1100111;
    localparam logic [6:0] LUI = 7'b0110111;

    typedef struct packed {
        logic       rst;
        logic       busy;
        logic       br;
        logic       ld;
        logic [6:0] op;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] dest;
    } in_t;

    typedef struct {
        in_t        in;
        logic [8:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;

    hazard_stall_ctrl_if hz_if ();

    hazard_stall_ctrl #(.STALL_LIMIT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz_if.slave)
    );

    always #5 clk = ~clk;

    // Model: what happened last cycle decides what may happen now.
    logic m_prev_busy, m_prev_flush, m_prev_lu, m_pending, m_sticky;
    int   m_busy_run;

    function automatic in_t mk(logic rst, logic busy, logic br, logic ld, logic [6:0] op,
                               logic [4:0] rs1, logic [4:0] rs2, logic [4:0] dest);
        in_t v;
        v.rst = rst; v.busy = busy; v.br = br; v.ld = ld;
        v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.dest = dest;
        return v;
    endfunction

    // {pc, if_id, id_ex, ex_mem, bubble, flush, timeout, state[1:0]}
    function automatic logic [8:0] ex(logic pc, logic ifid, logic idex, logic exmem,
                                      logic bub, logic fl, logic to, logic [1:0] st);
        return {pc, ifid, idex, exmem, bub, fl, to, st};
    endfunction

    function automatic logic model_lu(in_t v);
        logic r1, r2;
        r1 = v.op inside {BRANCH, STORE, OPR, LOAD, OPIMM, JALR};
        r2 = v.op inside {BRANCH, STORE, OPR};
        return v.ld && v.dest != 0 && ((r1 && v.rs1 == v.dest) || (r2 && v.rs2 == v.dest));
    endfunction

    task automatic model_step(input in_t v, output logic [8:0] e);
        logic [1:0] st;
        logic do_mem, do_flush, do_lu;
        st = m_prev_busy ? 2'd2 : m_prev_flush ? 2'd3 : m_prev_lu ? 2'd1 : 2'd0;
        do_mem = 0; do_flush = 0; do_lu = 0;
        if (!v.rst) begin
            if (v.busy) do_mem = 1;
            else if (!(m_prev_flush || m_prev_lu)) begin
                if (v.br || (m_prev_busy && m_pending)) do_flush = 1;
                else if (model_lu(v)) do_lu = 1;
            end
        end
        e = ex(do_mem | do_lu, do_mem | do_lu, do_mem, do_mem,
               do_flush | do_lu, do_flush, m_sticky, st);
        if (v.rst) begin
            m_prev_busy = 0; m_prev_flush = 0; m_prev_lu = 0;
            m_pending = 0; m_sticky = 0; m_busy_run = 0;
        end else begin
            m_pending    = v.busy ? (m_pending | v.br) : 1'b0;
            m_busy_run   = v.busy ? m_busy_run + 1 : 0;
            // After n consecutive busy cycles the controller sits in its n-th wait cycle.
            if (m_busy_run >= 15) m_sticky = 1;
            m_prev_busy  = do_mem;
            m_prev_flush = do_flush;
            m_prev_lu    = do_lu;
        end
    endtask

    task automatic apply(input in_t v);
        reset                    = v.rst;
        hz_if.mem_busy_ip        = v.busy;
        hz_if.branch_taken_ip    = v.br;
        hz_if.ID_EX_is_load_ip   = v.ld;
        hz_if.id_instr_opcode_ip = v.op;
        hz_if.ID_dest_rs1_ip     = v.rs1;
        hz_if.ID_dest_rs2_ip     = v.rs2;
        hz_if.ID_EX_dest_ip      = v.dest;
    endtask

    task automatic tick(input in_t v, output logic [8:0] act, output logic [8:0] mexp);
        @(negedge clk);
        apply(v);
        #1;
        act = {hz_if.pc_stall_op, hz_if.if_id_stall_op, hz_if.id_ex_stall_op,
               hz_if.ex_mem_stall_op, hz_if.id_ex_bubble_op, hz_if.if_id_flush_op,
               hz_if.stall_timeout_op, hz_if.state_op};
        model_step(v, mexp);
    endtask

    task automatic chk(input string nm, input int idx, input logic [8:0] act, input logic [8:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %b expected %b", nm, idx, act, exp);
        end
    endtask

    vec_t vq[$];
    in_t  idle, v;
    logic [8:0] act, mexp;

    initial begin
        idle = mk(0, 0, 0, 0, LUI, 0, 0, 0);
        vq.push_back('{mk(1, 1, 1, 0, OPR, 0, 0, 0), ex(0,0,0,0,0,0,0,0)});
        vq.push_back('{mk(0, 0, 0, 1, OPR, 5, 1, 5), ex(1,1,0,0,1,0,0,0)});
        vq.push_back('{mk(0, 0, 0, 1, OPR, 5, 1, 5), ex(0,0,0,0,0,0,0,1)});
        vq.push_back('{idle,                         ex(0,0,0,0,0,0,0,0)});
        vq.push_back('{mk(0, 0, 0, 1, OPR, 0, 0, 0), ex(0,0,0,0,0,0,0,0)});
        vq.push_back('{mk(0, 0, 0, 1, OPIMM, 1, 7, 7), ex(0,0,0,0,0,0,0,0)});
        vq.push_back('{mk(0, 0, 0, 1, LUI, 7, 7, 7), ex(0,0,0,0,0,0,0,0)});
        vq.push_back('{mk(0, 0, 0, 1, STORE, 2, 7, 7), ex(1,1,0,0,1,0,0,0)});
        vq.push_back('{idle,                         ex(0,0,0,0,0,0,0,1)});
        vq.push_back('{mk(0, 0, 1, 0, OPR, 0, 0, 0), ex(0,0,0,0,1,1,0,0)});
        vq.push_back('{idle,                         ex(0,0,0,0,0,0,0,3)});
        vq.push_back('{idle,                         ex(0,0,0,0,0,0,0,0)});
        vq.push_back('{mk(0, 1, 0, 0, OPR, 0, 0, 0), ex(1,1,1,1,0,0,0,0)});
        vq.push_back('{mk(0, 1, 1, 0, OPR, 0, 0, 0), ex(1,1,1,1,0,0,0,2)});
        vq.push_back('{mk(0, 1, 0, 0, OPR, 0, 0, 0), ex(1,1,1,1,0,0,0,2)});
        vq.push_back('{mk(0, 1, 0, 0, OPR, 0, 0, 0), ex(1,1,1,1,0,0,0,2)});
        vq.push_back('{idle,                         ex(0,0,0,0,1,1,0,2)});
        vq.push_back('{idle,                         ex(0,0,0,0,0,0,0,3)});
        vq.push_back('{idle,                         ex(0,0,0,0,0,0,0,0)});
        vq.push_back('{mk(0, 1, 1, 0, OPR, 0, 0, 0), ex(1,1,1,1,0,0,0,0)});
        vq.push_back('{mk(1, 1, 1, 0, OPR, 0, 0, 0), ex(0,0,0,0,0,0,0,2)});
        vq.push_back('{idle,                         ex(0,0,0,0,0,0,0,0)});
        vq.push_back('{mk(0, 0, 0, 1, JALR, 3, 0, 3), ex(1,1,0,0,1,0,0,0)});
        vq.push_back('{mk(0, 1, 0, 1, JALR, 3, 0, 3), ex(1,1,1,1,0,0,0,1)});
        vq.push_back('{idle,                         ex(0,0,0,0,0,0,0,2)});
        vq.push_back('{mk(0, 0, 1, 1, BRANCH, 4, 4, 4), ex(0,0,0,0,1,1,0,0)});
        vq.push_back('{mk(0, 0, 1, 1, BRANCH, 4, 4, 4), ex(0,0,0,0,0,0,0,3)});
        vq.push_back('{idle,                         ex(0,0,0,0,0,0,0,0)});

        apply(mk(1, 0, 0, 0, LUI, 0, 0, 0));
        m_prev_busy = 0; m_prev_flush = 0; m_prev_lu = 0;
        m_pending = 0; m_sticky = 0; m_busy_run = 0;
        @(posedge clk);

        foreach (vq[i]) begin
            tick(vq[i].in, act, mexp);
            chk("vec", i, act, vq[i].exp);
        end

        // Memory held busy for 20 cycles; flag must show from the 15th wait cycle.
        for (int k = 1; k <= 20; k++) begin
            tick(mk(0, 1, 0, 0, OPR, 0, 0, 0), act, mexp);
            chk("timeout_busy", k, act, ex(1, 1, 1, 1, 0, 0, k >= 16, (k == 1) ? 2'd0 : 2'd2));
        end
        tick(idle, act, mexp);
        chk("timeout_release", 0, act, ex(0,0,0,0,0,0,1,2));
        tick(idle, act, mexp);
        chk("timeout_hold", 0, act, ex(0,0,0,0,0,0,1,0));
        tick(mk(1, 1, 0, 0, OPR, 0, 0, 0), act, mexp);
        chk("timeout_in_reset", 0, act, ex(0,0,0,0,0,0,1,0));
        tick(idle, act, mexp);
        chk("timeout_cleared", 0, act, ex(0,0,0,0,0,0,0,0));

        for (int n = 0; n < 3000; n++) begin
            logic [6:0] ops [8];
            ops[0] = BRANCH; ops[1] = STORE; ops[2] = OPR; ops[3] = LOAD;
            ops[4] = OPIMM;  ops[5] = JALR;  ops[6] = LUI; ops[7] = 7'b1101111;
            v = mk(($urandom_range(99) < 2), 1'b0, ($urandom_range(99) < 15),
                   ($urandom_range(1) == 1), ops[$urandom_range(7)],
                   5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)));
            // Long busy bursts now and then so the timeout path gets exercised.
            v.busy = (n % 400 >= 100 && n % 400 < 120) ? 1'b1 : ($urandom_range(99) < 20);
            tick(v, act, mexp);
            chk("random", n, act, mexp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 SHALL have parameter STALL_LIMIT, default 15, max consecutive MEM_WAIT cycles before timeout flag.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port id_instr_opcode_ip  input  7  opcode of instruction in ID.
REQ-005 SHALL have ports ID_dest_rs1_ip, ID_dest_rs2_ip  input  5 each  source registers of the instruction in ID.
REQ-006 SHALL have port ID_EX_dest_ip  input  5  destination register of the instruction in EX.
REQ-007 SHALL have port ID_EX_is_load_ip  input  1  instruction in EX is a load.
REQ-008 SHALL have port branch_taken_ip  input  1  EX resolved a taken branch or jump.
REQ-009 SHALL have port mem_busy_ip  input  1  data memory has not completed the access.
REQ-010 SHALL have ports pc_stall_op, if_id_stall_op, id_ex_stall_op, ex_mem_stall_op  output  1 each  hold the named register.
REQ-011 SHALL have ports id_ex_bubble_op, if_id_flush_op  output  1 each  load a NOP into the named register.
REQ-012 SHALL have port stall_timeout_op  output  1  sticky MEM_WAIT timeout flag.
REQ-013 SHALL have port state_op  output  2  current FSM state.

Function
REQ-014 SHALL implement states RUN=0, LU_STALL=1, MEM_WAIT=2, FLUSH=3.
REQ-015 SHALL treat rs1 as read for opcodes BRANCH, STORE, OP, LOAD, OPIMM and JALR (1100111), and rs2 as read for BRANCH, STORE and OP only.
REQ-016 SHALL define load_use = ID_EX_is_load_ip && ID_EX_dest_ip!=0 && (rs1 read and matching || rs2 read and matching).
REQ-017 SHALL drive stall/flush outputs combinationally in the cycle of detection, with priority mem_busy_ip > branch_taken_ip > load_use.
REQ-018 When mem_busy_ip=1 in any state, SHALL assert all four stall outputs, deassert bubble and flush, and move next to MEM_WAIT.
REQ-019 When in RUN with branch_taken_ip=1 and mem_busy_ip=0, SHALL assert if_id_flush_op and id_ex_bubble_op for that cycle only, and move next to FLUSH.
REQ-020 When in RUN with load_use=1 and no higher-priority event, SHALL assert pc_stall_op, if_id_stall_op and id_ex_bubble_op, and move next to LU_STALL.
REQ-021 In LU_STALL and FLUSH with mem_busy_ip=0, SHALL ignore load_use, assert no outputs, and return to RUN after exactly one cycle.
REQ-022 SHALL latch branch_taken_ip asserted during MEM_WAIT into a pending_flush bit. When mem_busy_ip falls, it SHALL apply the REQ-019 flush in that same cycle if the bit is set, and clear the bit.
REQ-023 SHALL count consecutive MEM_WAIT cycles in a 5-bit saturating counter, cleared on leaving MEM_WAIT.
REQ-024 When the counter reaches STALL_LIMIT, SHALL set stall_timeout_op and hold it until reset.
REQ-025 With no hazard in RUN, SHALL keep all stall, bubble and flush outputs at 0.

Reset
REQ-026 On reset=1 at a clock edge, SHALL force state RUN, clear pending_flush, the counter and stall_timeout_op, and clear the performance counters if present.
REQ-027 While reset=1, SHALL drive all stall, bubble and flush outputs to 0, overriding mem_busy_ip.
REQ-028 Reset asserted mid-MEM_WAIT or mid-FLUSH SHALL discard all pending work.

Configuration
REQ-029 SHALL recognise macro HAZARD_PERF_CNT_EN.
REQ-030 With HAZARD_PERF_CNT_EN defined, SHALL add 32-bit outputs lu_stall_cnt_op, mem_stall_cnt_op and flush_cnt_op. These SHALL count cycles in which each REQ-020, REQ-018 and REQ-019 action fires, and SHALL wrap at 2^32.
REQ-031 Without HAZARD_PERF_CNT_EN, these ports and counters SHALL be absent, with all other behaviour identical.

Verification
REQ-032 SHALL verify load-use: EX=load x5, ID=add x6,x5,x1 -> one cycle with pc/if_id stall and bubble=1, state LU_STALL, then RUN with outputs 0.
REQ-033 SHALL verify x0 and unused rs2: EX=load x0 with ID=add rs1=x0 gives no stall; EX=load x7 with ID=addi rs1=x1, rs2 field=7 gives no stall.
REQ-034 SHALL verify branch flush: branch_taken_ip=1 for one cycle -> if_id_flush and bubble=1 for one cycle, FLUSH for one cycle, then RUN.
REQ-035 SHALL verify memory wait with pending branch: mem_busy_ip=1 for 4 cycles, with branch_taken_ip pulsed in cycle 2 -> all stalls for 4 cycles, then flush asserted in the cycle mem_busy_ip falls.
REQ-036 SHALL verify timeout: mem_busy_ip held 20 cycles with STALL_LIMIT=15 -> stall_timeout_op=1 from the 15th MEM_WAIT cycle, stays 1 after mem_busy_ip falls, and clears only on reset.
REQ-037 SHALL verify reset mid-MEM_WAIT: reset=1 while mem_busy_ip=1 -> outputs 0, state RUN next cycle, pending_flush cleared.
